// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the data-memory responder.
//   MW_NONE / MW_STORE : store-strobe encodings (2'b10 / 2'b11 are illegal)
//   size_t             : access size decoded from the b / half qualifiers
//   size_of()          : b takes priority over half; neither means word
//   misaligned()       : true when the byte offset does not suit the size
package dmem_pkg;

  localparam logic [1:0] MW_NONE  = 2'b00;
  localparam logic [1:0] MW_STORE = 2'b01;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  function automatic size_t size_of(input logic b, input logic half);
    if (b)
      return SZ_BYTE;
    else if (half)
      return SZ_HALF;
    else
      return SZ_WORD;
  endfunction

  function automatic logic misaligned(input size_t size, input logic [1:0] offs);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offs[0];
      SZ_WORD: return (offs != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational lane extract and sign/zero extension of a
// little-endian 32-bit word. Shared by any responder that returns sized loads.
//   word      in  32  raw storage word
//   offs      in  2   byte offset within the word (addr[1:0])
//   size      in      access size
//   bunsigned in  1   1 = zero-extend, 0 = sign-extend
//   readdata  out 32  extracted value; 0 for a misaligned access
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offs,
  input  size_t       size,
  input  logic        bunsigned,
  output logic [31:0] readdata
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8 = word[7:0];
    case (offs)
      2'd0: lane8 = word[7:0];
      2'd1: lane8 = word[15:8];
      2'd2: lane8 = word[23:16];
      2'd3: lane8 = word[31:24];
      default: lane8 = word[7:0];
    endcase
    lane16 = offs[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    readdata = 32'h0;
    if (!misaligned(size, offs)) begin
      case (size)
        SZ_BYTE: readdata = {{24{~bunsigned & lane8[7]}}, lane8};
        SZ_HALF: readdata = {{16{~bunsigned & lane16[15]}}, lane16};
        SZ_WORD: readdata = word;
        default: readdata = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's data port. Word-organised
// little-endian array with byte-lane-merged stores, combinational sized loads,
// a sticky error capture for misaligned/illegal stores and a store counter.
//   clk       in  1      system clock
//   reset     in  1      async active-low reset (clears err/err_addr/store_cnt)
//   memwrite  in  2      00 none, 01 store, 1x illegal
//   half, b   in  1      size qualifiers (b wins)
//   bunsigned in  1      zero-extend loads when 1
//   addr      in  32     byte address
//   writedata in  32     right-justified store data
//   readdata  out 32     sized, extended load data
//   err       out 1      sticky error flag
//   err_addr  out 32     address of the first error
//   store_cnt out CNT_W  committed store count (wraps)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       memwrite,
  input  logic             half,
  input  logic             b,
  input  logic             bunsigned,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  size_t         size;
  logic          mis;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          store_ok;
  logic          err_ev;

  // Upper address bits are dropped here, so the index wraps modulo the depth.
  assign idx      = addr[AW+1:2];
  assign size     = size_of(b, half);
  assign mis      = misaligned(size, addr[1:0]);
  assign store_ok = (memwrite == MW_STORE) && !mis;
  assign err_ev   = memwrite[1] || ((memwrite == MW_STORE) && mis);

  // Replicating the data onto every lane lets the byte enables alone pick
  // which lanes land, regardless of offset.
  always_comb begin
    be     = 4'b1111;
    wlanes = writedata;
    case (size)
      SZ_BYTE: begin
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{writedata[7:0]}};
      end
      SZ_HALF: begin
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{writedata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = writedata;
      end
    endcase
  end

  // Array is not reset; a low reset at the edge simply blocks the write.
  always_ff @(posedge clk) begin
    if (reset && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_addr  <= 32'h0;
      store_cnt <= '0;
    end else begin
      if (store_ok) store_cnt <= store_cnt + CNT_W'(1);
      if (err_ev && !err) begin
        err      <= 1'b1;
        err_addr <= addr;
      end
    end
  end

  dmem_load_align u_align (
    .word      (mem[idx]),
    .offs      (addr[1:0]),
    .size      (size),
    .bunsigned (bunsigned),
    .readdata  (readdata)
  );

endmodule
